// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer: state encoding,
// instruction opcodes, IR field positions and the decoded opcode class.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StReset,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaMsb     = 26;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbMsb     = 22;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcMsb     = 18;
  localparam int unsigned RcLsb     = 15;

  typedef struct packed {
    logic binary;
    logic unary;
    logic muldiv;
    logic nop;
    logic halt;
    logic illegal;
  } op_class_t;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/ir_decoder.sv
// Combinational IR decode: opcode class and one-hot Ra/Rb/Rc register selects.
// Optional macro MULDIV_EN: when undefined, mul/div decode as illegal.
module ir_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_t   op_class,
  output logic [4:0]  alu_op,
  output logic [15:0] ra_oh,
  output logic [15:0] rb_oh,
  output logic [15:0] rc_oh
);

  // The low IR bits carry immediates for instruction classes this unit does not handle.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[RcLsb-1:0];

  assign alu_op = ir[OpcodeMsb:OpcodeLsb];
  assign ra_oh  = onehot16(ir[RaMsb:RaLsb]);
  assign rb_oh  = onehot16(ir[RbMsb:RbLsb]);
  assign rc_oh  = onehot16(ir[RcMsb:RcLsb]);

  always_comb begin
    op_class = '0;
    case (alu_op)
      OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl: op_class.binary = 1'b1;
      OpMul, OpDiv: begin
`ifdef MULDIV_EN
        op_class.muldiv = 1'b1;
`else
        op_class.illegal = 1'b1;
`endif
      end
      OpNeg, OpNot: op_class.unary   = 1'b1;
      OpNop:        op_class.nop     = 1'b1;
      OpHalt:       op_class.halt    = 1'b1;
      default:      op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch plus T0..T6 execute sequencing, Moore-decoded strobes.
// Optional macro MULDIV_EN enables the mul/div T4->T5->T6 sequence and HI/LO strobes.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] r_in,
  output logic [15:0] r_out,
  output logic [4:0]  opcode,
  output logic        running,
  output logic        illegal
);

  state_e      state_q, state_d;
  op_class_t   op_class;
  logic [4:0]  alu_op;
  logic [15:0] ra_oh, rb_oh, rc_oh;

  ir_decoder u_ir_decoder (
    .ir       (ir),
    .op_class (op_class),
    .alu_op   (alu_op),
    .ra_oh    (ra_oh),
    .rb_oh    (rb_oh),
    .rc_oh    (rc_oh)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ZHighIn  = 1'b0;
    ZLowIn   = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    r_in     = '0;
    r_out    = '0;
    opcode   = '0;
    illegal  = 1'b0;
    running  = (state_q != StReset) && (state_q != StHalt);

    unique case (state_q)
      StReset: state_d = StT0;
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        PCin    = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_rdy) state_d = StT2;
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (op_class.binary || op_class.muldiv) begin
          r_out   = rb_oh;
          Yin     = 1'b1;
          state_d = StT4;
        end else if (op_class.unary) begin
          r_out   = rb_oh;
          opcode  = alu_op;
          ZLowIn  = 1'b1;
          state_d = StT5;
        end else if (op_class.halt) begin
          state_d = StHalt;
        end else begin
          // Unsupported opcodes flag once and otherwise behave as nop.
          illegal = op_class.illegal;
          state_d = StT0;
        end
      end
      StT4: begin
        r_out  = rc_oh;
        opcode = alu_op;
        ZLowIn = 1'b1;
`ifdef MULDIV_EN
        ZHighIn = op_class.muldiv;
`endif
        state_d = StT5;
      end
      StT5: begin
        Zlowout = 1'b1;
        r_in    = ra_oh;
        state_d = StT0;
`ifdef MULDIV_EN
        if (op_class.muldiv) begin
          r_in    = '0;
          LOin    = 1'b1;
          state_d = StT6;
        end
`endif
      end
      StT6: begin
`ifdef MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
`endif
        state_d = StT0;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

endmodule
